qr_input_sequencer: RTL

Synthesizable stimulus streamer that feeds the QR_Engine input port from an on-chip pattern memory. It reads 48-bit H/y words from a synchronous single-port ROM/SRAM and presents them to the engine as contiguous 200-word groups of 10 REs on `o_trig`/`o_data`. After each group it stalls until the engine pulses its `o_last_data`. It sits between the pattern memory and `QR_Engine` and performs the engine's input handshake in hardware.

---
 rtl/qr_input_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/qr_input_sequencer.sv
// qr_input_sequencer: streams H/y words from pattern memory into QR_Engine in groups,
// stalling between groups until the engine signals group completion.
module qr_input_sequencer #(
    parameter int WORDS_PER_GROUP = 200,
    parameter int NUM_GROUPS      = 100,
    parameter int ADDR_W          = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [47:0]       i_mem_data,
    output logic              o_trig,
    output logic [47:0]       o_data,
    input  logic              i_last_data,
    output logic              o_busy,
    output logic              o_done
);
    localparam int WW = $clog2(WORDS_PER_GROUP + 1);
    localparam int GW = $clog2(NUM_GROUPS + 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WW-1:0]     word_q, word_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic              seen_q, seen_d;
    logic              v1_q, v1_d;
    logic              trig_q, trig_d;
    logic              done_q, done_d;
    logic [47:0]       data_q, data_d;

    assign o_mem_en   = state_q == STREAM;
    assign o_mem_addr = addr_q;
    assign o_trig     = trig_q;
    assign o_data     = data_q;
    assign o_busy     = state_q != IDLE;
    assign o_done     = done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        grp_d   = grp_q;
        seen_d  = seen_q;
        done_d  = 1'b0;
        v1_d    = o_mem_en;
        trig_d  = v1_q;
        data_d  = v1_q ? i_mem_data : data_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = STREAM;
                    addr_d  = '0;
                    word_d  = '0;
                    grp_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            STREAM: begin
                addr_d = addr_q + ADDR_W'(1);
                word_d = word_q + WW'(1);
                if (word_q == WW'(WORDS_PER_GROUP - 1)) begin
                    word_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                seen_d = seen_q | i_last_data;
                // Leave once no fetched word remains in stage 1; the final word's stage-2
                // slot drains while the next group's first fetch is still two cycles away.
                if (seen_d && !v1_q) begin
                    seen_d = 1'b0;
                    if (grp_q == GW'(NUM_GROUPS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        grp_d   = grp_q + GW'(1);
                        state_d = STREAM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            grp_q   <= '0;
            seen_q  <= 1'b0;
            v1_q    <= 1'b0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            grp_q   <= grp_d;
            seen_q  <= seen_d;
            v1_q    <= v1_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end
endmodule
